// File: rtl/uart_pkg.sv
// Shared constants for the UART APB register file: register indices,
// interrupt identification codes, bit positions and the RX trigger select.
package uart_pkg;

   localparam logic [5:0] IDX_RBR = 6'h00;
   localparam logic [5:0] IDX_IER = 6'h01;
   localparam logic [5:0] IDX_IIR = 6'h02;
   localparam logic [5:0] IDX_LCR = 6'h03;
   localparam logic [5:0] IDX_LSR = 6'h05;
   localparam logic [5:0] IDX_USR = 6'h1F;
   localparam logic [5:0] IDX_TFL = 6'h20;
   localparam logic [5:0] IDX_RFL = 6'h21;

   localparam logic [3:0] IID_LINE = 4'b0110;
   localparam logic [3:0] IID_RDA  = 4'b0100;
   localparam logic [3:0] IID_THRE = 4'b0010;
   localparam logic [3:0] IID_NONE = 4'b0001;

   localparam int IER_ERBFI = 0;
   localparam int IER_ETBEI = 1;
   localparam int IER_ELSI  = 2;

   localparam int FCR_FIFOE = 0;
   localparam int FCR_RXRST = 1;
   localparam int FCR_TXRST = 2;

   localparam int LSR_DR   = 0;
   localparam int LSR_OE   = 1;
   localparam int LSR_PE   = 2;
   localparam int LSR_FE   = 3;
   localparam int LSR_THRE = 5;
   localparam int LSR_TEMT = 6;
   localparam int LSR_RXFE = 7;

   localparam int USR_BUSY = 0;
   localparam int USR_TFNF = 1;
   localparam int USR_TFE  = 2;
   localparam int USR_RFNE = 3;
   localparam int USR_RFF  = 4;

   typedef enum logic [1:0] {
      TRIG_ONE       = 2'd0,
      TRIG_QUARTER   = 2'd1,
      TRIG_HALF      = 2'd2,
      TRIG_NEAR_FULL = 2'd3
   } trig_sel_e;

   function automatic int unsigned trig_level(input trig_sel_e sel, input int unsigned depth);
      case (sel)
         TRIG_ONE:     return 1;
         TRIG_QUARTER: return depth / 4;
         TRIG_HALF:    return depth / 2;
         default:      return depth - 2;
      endcase
   endfunction

endpackage

// File: rtl/uart_apb_fifo_reg_if.sv
// APB bus between the bridge (master) and the UART register file (slave).
interface uart_apb_fifo_reg_if;
   logic        apb_uart_psel;
   logic        apb_uart_penable;
   logic        apb_uart_pwrite;
   logic [7:0]  apb_uart_paddr;
   logic [31:0] apb_uart_pwdata;
   logic [31:0] uart_apb_prdata;

   modport master (
      output apb_uart_psel, apb_uart_penable, apb_uart_pwrite, apb_uart_paddr, apb_uart_pwdata,
      input  uart_apb_prdata
   );

   modport slave (
      input  apb_uart_psel, apb_uart_penable, apb_uart_pwrite, apb_uart_paddr, apb_uart_pwdata,
      output uart_apb_prdata
   );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with extra-bit pointers; cap_one limits it to a
// single entry so the same storage serves the legacy non-FIFO mode.
module uart_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic             cap_one,
   input  logic [W-1:0]     wdata,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level,
   output logic [W-1:0]     head
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [LVL_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic             do_push, do_pop;

   assign level   = wr_ptr_reg - rd_ptr_reg;
   assign empty   = (level == '0);
   assign full    = cap_one ? !empty : (level == LVL_W'(DEPTH));
   assign do_pop  = pop & !empty;
   // A same-cycle pop frees the slot a push into a full FIFO needs.
   assign do_push = push & (!full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr_reg[AW-1:0]] <= wdata;
   end

   assign head = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
endmodule

// File: rtl/uart_apb_fifo_reg.sv
// 16550-style UART register file on APB with TX/RX FIFOs, FCR, trigger
// level, FIFO level registers and prioritised interrupt identification.
module uart_apb_fifo_reg
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   uart_apb_fifo_reg_if.slave apb,
   input  logic               ctrl_reg_tx_pop,
   output logic               reg_ctrl_tx_vld,
   output logic [7:0]         reg_ctrl_tx_data,
   input  logic               ctrl_reg_rx_push,
   input  logic [7:0]         ctrl_reg_rx_data,
   input  logic               ctrl_reg_rx_fe,
   input  logic               ctrl_reg_rx_pe,
   input  logic               ctrl_reg_busy,
   input  logic               ctrl_reg_thsr_empty,
   output logic [15:0]        reg_ctrl_dllh_data,
   output logic [4:0]         reg_ctrl_lcr,
   output logic               reg_ctrl_set_dllh_vld,
   output logic               reg_ctrl_lcr_wen,
   output logic               uart_vic_int
);
   logic [5:0]       idx;
   logic [7:0]       wdata;
   logic             wr_acc, rd_acc, dlab, div_wr;
   logic             thr_wr, ier_wr, fcr_wr, lcr_wr, rbr_rd, lsr_rd, iir_rd;
   logic             fifoe_chg, tx_flush, rx_flush, rx_drop, thre_set, thre_clr;
   logic             tx_full, tx_empty, rx_full, rx_empty;
   logic [LVL_W-1:0] tx_level, rx_level, trig_lvl;
   logic [7:0]       tx_head, rx_head, lsr, usr;
   logic [3:0]       iid;
   logic [31:0]      rd_data;

   logic [2:0]       ier_reg;
   logic [7:0]       lcr_reg, dll_reg, dlh_reg;
   logic             fifoe_reg, fe_reg, pe_reg, oe_reg, rxfe_reg;
   logic             thre_pend_reg, tx_empty_d_reg, set_dllh_reg, lcr_wen_reg;
   trig_sel_e        trig_reg;
   logic             unused_bits;

   assign idx         = apb.apb_uart_paddr[7:2];
   assign wdata       = apb.apb_uart_pwdata[7:0];
   assign unused_bits = ^{apb.apb_uart_pwdata[31:8], apb.apb_uart_paddr[1:0], lcr_reg[6:5]};
   assign wr_acc      = apb.apb_uart_psel & apb.apb_uart_penable & apb.apb_uart_pwrite;
   assign rd_acc      = apb.apb_uart_psel & apb.apb_uart_penable & !apb.apb_uart_pwrite;
   assign dlab        = lcr_reg[7];

   assign thr_wr = wr_acc & (idx == IDX_RBR) & !dlab;
   assign ier_wr = wr_acc & (idx == IDX_IER) & !dlab;
   assign fcr_wr = wr_acc & (idx == IDX_IIR);
   assign lcr_wr = wr_acc & (idx == IDX_LCR);
   assign div_wr = wr_acc & dlab & !ctrl_reg_busy;
   assign rbr_rd = rd_acc & (idx == IDX_RBR) & !dlab;
   assign lsr_rd = rd_acc & (idx == IDX_LSR);
   assign iir_rd = rd_acc & (idx == IDX_IIR);

   assign fifoe_chg = fcr_wr & (wdata[FCR_FIFOE] != fifoe_reg);
   assign tx_flush  = (fcr_wr & wdata[FCR_TXRST]) | fifoe_chg;
   assign rx_flush  = (fcr_wr & wdata[FCR_RXRST]) | fifoe_chg;
   assign rx_drop   = ctrl_reg_rx_push & rx_full & !rbr_rd;

   uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8), .LVL_W(LVL_W)) u_tx_fifo (
      .clk(sys_clk), .rst(sys_rst), .push(thr_wr), .pop(ctrl_reg_tx_pop),
      .flush(tx_flush), .cap_one(!fifoe_reg), .wdata(wdata),
      .full(tx_full), .empty(tx_empty), .level(tx_level), .head(tx_head)
   );

   uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(8), .LVL_W(LVL_W)) u_rx_fifo (
      .clk(sys_clk), .rst(sys_rst), .push(ctrl_reg_rx_push), .pop(rbr_rd),
      .flush(rx_flush), .cap_one(!fifoe_reg), .wdata(ctrl_reg_rx_data),
      .full(rx_full), .empty(rx_empty), .level(rx_level), .head(rx_head)
   );

   // THRE pending arms on the edge into empty, not on the empty level itself.
   assign thre_set = (tx_empty & !tx_empty_d_reg) | (ier_wr & wdata[IER_ETBEI] & tx_empty);
   assign thre_clr = thr_wr | (iir_rd & (iid == IID_THRE));
   assign trig_lvl = fifoe_reg ? LVL_W'(trig_level(trig_reg, FIFO_DEPTH)) : LVL_W'(1);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         ier_reg        <= '0;
         lcr_reg        <= '0;
         dll_reg        <= '0;
         dlh_reg        <= '0;
         fifoe_reg      <= 1'b0;
         trig_reg       <= TRIG_ONE;
         fe_reg         <= 1'b0;
         pe_reg         <= 1'b0;
         oe_reg         <= 1'b0;
         rxfe_reg       <= 1'b0;
         thre_pend_reg  <= 1'b0;
         tx_empty_d_reg <= 1'b1;
         set_dllh_reg   <= 1'b0;
         lcr_wen_reg    <= 1'b0;
      end else begin
         set_dllh_reg   <= 1'b0;
         lcr_wen_reg    <= 1'b0;
         tx_empty_d_reg <= tx_empty;
         if (div_wr && idx == IDX_RBR) begin
            dll_reg      <= wdata;
            set_dllh_reg <= 1'b1;
         end
         if (div_wr && idx == IDX_IER) begin
            dlh_reg      <= wdata;
            set_dllh_reg <= 1'b1;
         end
         if (ier_wr) ier_reg <= wdata[2:0];
         if (fcr_wr) begin
            fifoe_reg <= wdata[FCR_FIFOE];
            trig_reg  <= trig_sel_e'(wdata[7:6]);
         end
         if (lcr_wr) begin
            lcr_reg     <= wdata;
            lcr_wen_reg <= 1'b1;
         end
         // A new error in the same cycle as the LSR read survives the clear.
         fe_reg   <= (fe_reg & !lsr_rd) | (ctrl_reg_rx_push & ctrl_reg_rx_fe);
         pe_reg   <= (pe_reg & !lsr_rd) | (ctrl_reg_rx_push & ctrl_reg_rx_pe);
         oe_reg   <= (oe_reg & !lsr_rd) | rx_drop;
         rxfe_reg <= (rxfe_reg & !lsr_rd) | (ctrl_reg_rx_push & (ctrl_reg_rx_fe | ctrl_reg_rx_pe));
         if (thre_clr)      thre_pend_reg <= 1'b0;
         else if (thre_set) thre_pend_reg <= 1'b1;
      end
   end

   always_comb begin
      iid = IID_NONE;
      if (ier_reg[IER_ELSI] && (oe_reg || pe_reg || fe_reg)) iid = IID_LINE;
      else if (ier_reg[IER_ERBFI] && (rx_level >= trig_lvl)) iid = IID_RDA;
      else if (ier_reg[IER_ETBEI] && thre_pend_reg)          iid = IID_THRE;
   end

   assign lsr = {rxfe_reg, tx_empty & ctrl_reg_thsr_empty, tx_empty, 1'b0, fe_reg, pe_reg, oe_reg, !rx_empty};
   assign usr = {3'b000, rx_full, !rx_empty, tx_empty, !tx_full, ctrl_reg_busy};

   always_comb begin
      rd_data = '0;
      if (rd_acc) begin
         case (idx)
            IDX_RBR: rd_data = {24'b0, dlab ? dll_reg : rx_head};
            IDX_IER: rd_data = {24'b0, dlab ? dlh_reg : {5'b0, ier_reg}};
            IDX_IIR: rd_data = {24'b0, fifoe_reg, fifoe_reg, 2'b00, iid};
            IDX_LCR: rd_data = {24'b0, lcr_reg};
            IDX_LSR: rd_data = {24'b0, lsr};
            IDX_USR: rd_data = {24'b0, usr};
            IDX_TFL: rd_data = 32'(tx_level);
            IDX_RFL: rd_data = 32'(rx_level);
            default: rd_data = '0;
         endcase
      end
   end

   assign apb.uart_apb_prdata   = rd_data;
   assign reg_ctrl_tx_vld       = !tx_empty;
   assign reg_ctrl_tx_data      = tx_head;
   assign reg_ctrl_dllh_data    = {dlh_reg, dll_reg};
   assign reg_ctrl_lcr          = lcr_reg[4:0];
   assign reg_ctrl_set_dllh_vld = set_dllh_reg;
   assign reg_ctrl_lcr_wen      = lcr_wen_reg;
   assign uart_vic_int          = (iid != IID_NONE);
endmodule

// File: tb/tb_uart_apb_fifo_reg.sv
// Bench for uart_apb_fifo_reg: register table, directed corner sequences and
// randomized traffic checked against a queue-based model of the register map.
module tb_uart_apb_fifo_reg;
   import uart_pkg::*;

   localparam int D = 16;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        tx_pop = 1'b0, tx_vld;
   logic [7:0]  tx_data;
   logic        rx_push = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_fe = 1'b0, rx_pe = 1'b0, busy = 1'b0, thsr_empty = 1'b1;
   logic [15:0] dllh;
   logic [4:0]  lcr_o;
   logic        dllh_vld, lcr_wen, vic_int;

   int checks = 0;
   int errors = 0;
   int dll_pulses = 0;

   always #5 sys_clk = ~sys_clk;

   uart_apb_fifo_reg_if apb_if ();

   uart_apb_fifo_reg #(.FIFO_DEPTH(D)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .apb(apb_if),
      .ctrl_reg_tx_pop(tx_pop), .reg_ctrl_tx_vld(tx_vld), .reg_ctrl_tx_data(tx_data),
      .ctrl_reg_rx_push(rx_push), .ctrl_reg_rx_data(rx_data),
      .ctrl_reg_rx_fe(rx_fe), .ctrl_reg_rx_pe(rx_pe),
      .ctrl_reg_busy(busy), .ctrl_reg_thsr_empty(thsr_empty),
      .reg_ctrl_dllh_data(dllh), .reg_ctrl_lcr(lcr_o),
      .reg_ctrl_set_dllh_vld(dllh_vld), .reg_ctrl_lcr_wen(lcr_wen),
      .uart_vic_int(vic_int)
   );

   always @(posedge sys_clk) if (dllh_vld) dll_pulses <= dll_pulses + 1;

   // ---------------- reference model state ----------------
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   bit         m_fifoe = 0;
   logic [1:0] m_trig = 2'd0;
   logic [2:0] m_ier = 3'd0;
   bit         m_fe = 0, m_pe = 0, m_oe = 0, m_rxfe = 0, m_pend = 0;

   function automatic int cap();
      return m_fifoe ? D : 1;
   endfunction

   function automatic int trig();
      if (!m_fifoe) return 1;
      case (m_trig)
         2'd0:    return 1;
         2'd1:    return D / 4;
         2'd2:    return D / 2;
         default: return D - 2;
      endcase
   endfunction

   function automatic logic [3:0] m_iid();
      if (m_ier[2] && (m_oe || m_pe || m_fe)) return 4'b0110;
      if (m_ier[0] && rxq.size() >= trig())   return 4'b0100;
      if (m_ier[1] && m_pend)                 return 4'b0010;
      return 4'b0001;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apb_xfer(input bit wr, input logic [5:0] idx, input logic [7:0] wd,
                           input bit rp, input logic [7:0] rb, input bit fe, input bit pe,
                           output logic [31:0] rdat);
      @(posedge sys_clk); #1;
      apb_if.apb_uart_psel    = 1'b1;
      apb_if.apb_uart_penable = 1'b0;
      apb_if.apb_uart_pwrite  = wr;
      apb_if.apb_uart_paddr   = {idx, 2'b00};
      apb_if.apb_uart_pwdata  = {24'hA55A5A, wd};
      @(posedge sys_clk); #1;
      apb_if.apb_uart_penable = 1'b1;
      rx_push = rp; rx_data = rb; rx_fe = fe; rx_pe = pe;
      @(negedge sys_clk);
      rdat = apb_if.uart_apb_prdata;
      @(posedge sys_clk); #1;
      apb_if.apb_uart_psel = 1'b0; apb_if.apb_uart_penable = 1'b0; apb_if.apb_uart_pwrite = 1'b0;
      rx_push = 1'b0; rx_fe = 1'b0; rx_pe = 1'b0;
      $display("apb %s idx=%02h wdata=%02h rdata=%02h push=%0d", wr ? "WR" : "RD", idx, wd, rdat[7:0], rp);
   endtask

   task automatic m_push(input logic [7:0] b, input bit fe, input bit pe);
      if (fe) begin m_fe = 1; m_rxfe = 1; end
      if (pe) begin m_pe = 1; m_rxfe = 1; end
      if (rxq.size() < cap()) rxq.push_back(b);
      else m_oe = 1;
   endtask

   task automatic m_thr_write(input logic [7:0] b);
      logic [31:0] r;
      apb_xfer(1, IDX_RBR, b, 0, 8'h00, 0, 0, r);
      if (txq.size() < cap()) txq.push_back(b);
      m_pend = 0;
   endtask

   task automatic m_tx_pop();
      logic [7:0] exp;
      @(posedge sys_clk); #1;
      tx_pop = 1'b1;
      @(negedge sys_clk);
      exp = (txq.size() != 0) ? txq[0] : 8'h00;
      chk("tx_pop_vld", {31'b0, tx_vld}, {31'b0, txq.size() != 0});
      chk("tx_pop_data", {24'b0, tx_data}, {24'b0, exp});
      @(posedge sys_clk); #1;
      tx_pop = 1'b0;
      $display("ctrl tx_pop data=%02h", exp);
      if (txq.size() != 0) begin
         void'(txq.pop_front());
         if (txq.size() == 0) m_pend = 1;
      end
   endtask

   task automatic m_rx_push(input logic [7:0] b, input bit fe, input bit pe);
      @(posedge sys_clk); #1;
      rx_push = 1'b1; rx_data = b; rx_fe = fe; rx_pe = pe;
      @(posedge sys_clk); #1;
      rx_push = 1'b0; rx_fe = 1'b0; rx_pe = 1'b0;
      $display("ctrl rx_push data=%02h fe=%0d pe=%0d", b, fe, pe);
      m_push(b, fe, pe);
   endtask

   task automatic m_rbr_read(input bit rp, input logic [7:0] b, input bit fe, input bit pe);
      logic [31:0] r, exp;
      exp = (rxq.size() != 0) ? {24'b0, rxq[0]} : 32'h0;
      apb_xfer(0, IDX_RBR, 8'h00, rp, b, fe, pe, r);
      chk("rbr", r, exp);
      if (rxq.size() != 0) void'(rxq.pop_front());
      if (rp) m_push(b, fe, pe);
   endtask

   task automatic m_read(input logic [5:0] idx, output logic [31:0] r);
      logic [31:0] exp;
      logic [3:0]  iid;
      string       nm;
      iid = m_iid();
      exp = 32'h0;
      nm  = "unmapped";
      case (idx)
         IDX_LSR: begin
            nm  = "lsr";
            exp = {24'b0, m_rxfe, (txq.size() == 0) && thsr_empty, txq.size() == 0,
                   1'b0, m_fe, m_pe, m_oe, rxq.size() != 0};
         end
         IDX_IIR: begin nm = "iir"; exp = {24'b0, m_fifoe, m_fifoe, 2'b00, iid}; end
         IDX_USR: begin
            nm  = "usr";
            exp = {27'b0, rxq.size() == cap(), rxq.size() != 0, txq.size() == 0,
                   txq.size() < cap(), busy};
         end
         IDX_TFL: begin nm = "tfl"; exp = txq.size(); end
         IDX_RFL: begin nm = "rfl"; exp = rxq.size(); end
         IDX_IER: begin nm = "ier"; exp = {29'b0, m_ier}; end
         default: ;
      endcase
      apb_xfer(0, idx, 8'h00, 0, 8'h00, 0, 0, r);
      chk(nm, r, exp);
      if (idx == IDX_LSR) begin m_fe = 0; m_pe = 0; m_oe = 0; m_rxfe = 0; end
      if (idx == IDX_IIR && iid == 4'b0010) m_pend = 0;
   endtask

   task automatic m_ier_write(input logic [7:0] v);
      logic [31:0] r;
      apb_xfer(1, IDX_IER, v, 0, 8'h00, 0, 0, r);
      m_ier = v[2:0];
      if (v[1] && txq.size() == 0) m_pend = 1;
   endtask

   task automatic m_fcr_write(input logic [7:0] v);
      logic [31:0] r;
      bit          chg;
      apb_xfer(1, IDX_IIR, v, 0, 8'h00, 0, 0, r);
      chg = (v[0] != m_fifoe);
      if (v[1] || chg) rxq.delete();
      if (v[2] || chg) begin
         if (txq.size() != 0) m_pend = 1;
         txq.delete();
      end
      m_fifoe = v[0];
      m_trig  = v[7:6];
   endtask

   task automatic check_out();
      @(posedge sys_clk); #1;
      chk("uart_vic_int", {31'b0, vic_int}, {31'b0, m_iid() != 4'b0001});
      chk("tx_vld", {31'b0, tx_vld}, {31'b0, txq.size() != 0});
      chk("tx_data", {24'b0, tx_data}, {24'b0, (txq.size() != 0) ? txq[0] : 8'h00});
   endtask

   typedef struct {
      bit          wr;
      logic [5:0]  idx;
      logic [7:0]  wd;
      bit          chk_en;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[18];

   initial begin
      logic [31:0] r;
      logic [7:0]  b;
      int          base;

      apb_if.apb_uart_psel = 1'b0; apb_if.apb_uart_penable = 1'b0;
      apb_if.apb_uart_pwrite = 1'b0; apb_if.apb_uart_paddr = 8'h00; apb_if.apb_uart_pwdata = 32'h0;

      vecs[0]  = '{0, IDX_LSR, 8'h00, 1, 32'h60, "lsr_reset"};
      vecs[1]  = '{0, IDX_IIR, 8'h00, 1, 32'h01, "iir_reset"};
      vecs[2]  = '{0, IDX_USR, 8'h00, 1, 32'h06, "usr_reset"};
      vecs[3]  = '{0, IDX_IER, 8'h00, 1, 32'h00, "ier_reset"};
      vecs[4]  = '{0, IDX_TFL, 8'h00, 1, 32'h00, "tfl_reset"};
      vecs[5]  = '{0, IDX_RFL, 8'h00, 1, 32'h00, "rfl_reset"};
      vecs[6]  = '{0, IDX_LCR, 8'h00, 1, 32'h00, "lcr_reset"};
      vecs[7]  = '{0, 6'h10,   8'h00, 1, 32'h00, "unmapped_rd"};
      vecs[8]  = '{0, IDX_RBR, 8'h00, 1, 32'h00, "rbr_empty"};
      vecs[9]  = '{1, IDX_LCR, 8'h1B, 0, 32'h00, "lcr_wr"};
      vecs[10] = '{0, IDX_LCR, 8'h00, 1, 32'h1B, "lcr_rd"};
      vecs[11] = '{1, 6'h10,   8'hFF, 0, 32'h00, "unmapped_wr"};
      vecs[12] = '{0, 6'h10,   8'h00, 1, 32'h00, "unmapped_rd2"};
      vecs[13] = '{1, IDX_IER, 8'h05, 0, 32'h00, "ier_wr"};
      vecs[14] = '{0, IDX_IER, 8'h00, 1, 32'h05, "ier_rd"};
      vecs[15] = '{0, IDX_IIR, 8'h00, 1, 32'h01, "iir_no_cause"};
      vecs[16] = '{1, IDX_IER, 8'h00, 0, 32'h00, "ier_clr"};
      vecs[17] = '{1, IDX_LCR, 8'h00, 0, 32'h00, "lcr_clr"};

      repeat (3) @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      @(negedge sys_clk);
      chk("rst_int", {31'b0, vic_int}, 32'h0);
      chk("rst_tx_vld", {31'b0, tx_vld}, 32'h0);
      chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
      chk("rst_dllh", {16'b0, dllh}, 32'h0);
      chk("rst_lcr", {27'b0, lcr_o}, 32'h0);
      chk("rst_pulses", {30'b0, dllh_vld, lcr_wen}, 32'h0);
      chk("rst_prdata", apb_if.uart_apb_prdata, 32'h0);

      for (int i = 0; i < 18; i++) begin
         apb_xfer(vecs[i].wr, vecs[i].idx, vecs[i].wd, 0, 8'h00, 0, 0, r);
         if (vecs[i].chk_en) chk(vecs[i].name, r, vecs[i].exp);
      end
      apb_xfer(1, IDX_LCR, 8'h0B, 0, 8'h00, 0, 0, r);
      @(negedge sys_clk);
      chk("lcr_out", {27'b0, lcr_o}, 32'h0B);
      apb_xfer(1, IDX_LCR, 8'h00, 0, 8'h00, 0, 0, r);

      // TX fill past capacity, drain in order, THRE interrupt.
      m_fcr_write(8'h01);
      for (int i = 0; i < 17; i++) m_thr_write(8'(8'h40 + i));
      m_read(IDX_TFL, r);
      chk("tfl_full", r, 32'd16);
      m_ier_write(8'h02);
      check_out();
      for (int i = 0; i < 16; i++) m_tx_pop();
      check_out();
      m_read(IDX_LSR, r);
      chk("lsr_thre", {31'b0, r[LSR_THRE]}, 32'd1);
      m_read(IDX_IIR, r);
      chk("iir_thre", r, 32'hC2);
      m_read(IDX_IIR, r);
      chk("iir_thre_cleared", r, 32'hC1);

      // RX trigger at DEPTH/2.
      m_fcr_write(8'h81);
      m_ier_write(8'h01);
      for (int i = 0; i < 7; i++) m_rx_push(8'(8'h80 + i), 0, 0);
      check_out();
      chk("int_below_trig", {31'b0, vic_int}, 32'd0);
      m_rx_push(8'h87, 0, 0);
      check_out();
      m_read(IDX_IIR, r);
      chk("iir_rda", r, 32'hC4);
      for (int i = 0; i < 8; i++) m_rbr_read(0, 8'h00, 0, 0);
      m_read(IDX_LSR, r);
      chk("lsr_dr_clear", {31'b0, r[LSR_DR]}, 32'd0);

      // RX overrun, then full push hidden by a same-cycle RBR read.
      for (int i = 0; i < 16; i++) m_rx_push(8'(8'h10 + i), 0, 0);
      m_rx_push(8'hEE, 0, 0);
      m_ier_write(8'h05);
      m_read(IDX_IIR, r);
      chk("iir_line", r, 32'hC6);
      m_read(IDX_LSR, r);
      chk("lsr_oe", {31'b0, r[LSR_OE]}, 32'd1);
      m_rbr_read(1, 8'h5C, 0, 0);
      m_read(IDX_RFL, r);
      chk("rfl_stays_full", r, 32'd16);
      m_read(IDX_LSR, r);
      chk("lsr_no_oe", {31'b0, r[LSR_OE]}, 32'd0);
      check_out();
      m_fcr_write(8'h83);
      m_ier_write(8'h00);

      // Legacy depth-1 mode.
      m_fcr_write(8'h00);
      m_thr_write(8'hA1);
      m_thr_write(8'hB2);
      m_read(IDX_TFL, r);
      chk("legacy_tfl", r, 32'd1);
      m_tx_pop();
      m_tx_pop();
      m_rx_push(8'h33, 0, 1);
      m_read(IDX_LSR, r);
      chk("lsr_pe_set", {30'b0, r[LSR_RXFE], r[LSR_PE]}, 32'd3);
      m_read(IDX_LSR, r);
      chk("lsr_pe_clear", {30'b0, r[LSR_RXFE], r[LSR_PE]}, 32'd0);
      m_rbr_read(0, 8'h00, 0, 0);
      check_out();

      // Divisor latch access and busy interlock.
      apb_xfer(1, IDX_LCR, 8'h80, 0, 8'h00, 0, 0, r);
      busy = 1'b1;
      base = dll_pulses;
      apb_xfer(1, IDX_RBR, 8'h55, 0, 8'h00, 0, 0, r);
      repeat (2) @(posedge sys_clk); #1;
      chk("dll_busy_ignored", {16'b0, dllh}, 32'h0);
      chk("dll_busy_no_pulse", dll_pulses - base, 32'd0);
      busy = 1'b0;
      apb_xfer(1, IDX_RBR, 8'h1B, 0, 8'h00, 0, 0, r);
      repeat (2) @(posedge sys_clk); #1;
      chk("dll_pulse_once", dll_pulses - base, 32'd1);
      apb_xfer(1, IDX_IER, 8'h00, 0, 8'h00, 0, 0, r);
      repeat (2) @(posedge sys_clk); #1;
      chk("dllh_data", {16'b0, dllh}, 32'h001B);
      apb_xfer(0, IDX_RBR, 8'h00, 0, 8'h00, 0, 0, r);
      chk("dll_readback", r, 32'h1B);
      apb_xfer(1, IDX_LCR, 8'h00, 0, 8'h00, 0, 0, r);

      // Randomized traffic against the model.
      m_fcr_write(8'h41);
      m_ier_write(8'(($urandom_range(0, 7))));
      for (int n = 0; n < 400; n++) begin
         int sel;
         sel = $urandom_range(0, 11);
         b   = 8'($urandom_range(0, 255));
         case (sel)
            0, 1: m_thr_write(b);
            2, 3: m_tx_pop();
            4, 5: m_rx_push(b, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            6:    m_rbr_read(0, 8'h00, 0, 0);
            7:    m_rbr_read(1, b, $urandom_range(0, 7) == 0, 0);
            8: begin
               logic [5:0] ridx;
               case ($urandom_range(0, 5))
                  0: ridx = IDX_LSR;
                  1: ridx = IDX_IIR;
                  2: ridx = IDX_USR;
                  3: ridx = IDX_TFL;
                  4: ridx = IDX_RFL;
                  default: ridx = IDX_IER;
               endcase
               thsr_empty = 1'($urandom_range(0, 1));
               busy       = 1'($urandom_range(0, 1));
               m_read(ridx, r);
               busy = 1'b0;
            end
            9: m_ier_write(8'($urandom_range(0, 7)));
            10: begin
               logic [7:0] f;
               f = {2'($urandom_range(0, 3)), 3'b000,
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 7) != 0)};
               m_fcr_write(f);
            end
            default: @(posedge sys_clk);
         endcase
         check_out();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
